rx_iq_serializer: RTL

Parametrised receiver-sample serializer between the NR-channel DDC bank and the Ethernet packetizer. On each common decimation strobe it snapshots the I/Q words of all receivers, then streams the active channels as big-endian bytes over a valid/ready interface with first/last markers. It generalises the fixed 9-receiver, 24-bit arrangement to any channel count and sample width, and adds a runtime active-channel count plus overrun detection and counting.

---
 rtl/rx_iq_serializer_if.sv | 25 ++
 rtl/rx_iq_serializer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rx_iq_serializer_if.sv
// Byte-stream handshake bundle between the I/Q serializer and the packetizer.
// The serializer drives data, valid and framing markers; the sink drives ready.
interface rx_iq_serializer_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_first;
    logic       out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_first,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_first,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/rx_iq_serializer.sv
// Snapshots all receiver I/Q words on a decimation strobe and streams the active
// channels as big-endian bytes (I then Q per channel), with overrun accounting.
module rx_iq_serializer #(
    parameter int NR  = 9,
    parameter int IQW = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_strobe,
    input  logic [NR*2*IQW-1:0]   rx_data,
    input  logic [4:0]            nrx,
    input  logic                  ovr_clr,
    output logic                  ovr_flag,
    output logic [7:0]            ovr_count,
    rx_iq_serializer_if.master    out_if
);
    localparam int BPW = IQW / 8;
    localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int SW  = NR * 2 * IQW;
    localparam int PW  = $clog2(SW);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   snap_q, snap_d;
    logic [4:0]      n_q, n_d;
    logic [4:0]      ch_q, ch_d;
    logic            iq_q, iq_d;
    logic [BW-1:0]   byte_q, byte_d;
    logic            ovr_flag_q, ovr_flag_d;
    logic [7:0]      ovr_count_q, ovr_count_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            first_q, first_d;
    logic            last_q, last_d;

    logic            hs;
    logic            at_last_q;
    logic            drop;
    logic [4:0]      n_eff;
    logic [PW-1:0]   pos_d;

    function automatic logic is_last(logic [4:0] ch, logic iq, logic [BW-1:0] b, logic [4:0] n);
        return (ch == n - 5'd1) && iq && (b == BW'(BPW - 1));
    endfunction

    // iq=0 selects I, which occupies the upper half of each channel's word pair
    function automatic logic [PW-1:0] byte_pos(logic [4:0] ch, logic iq, logic [BW-1:0] b);
        int p;
        p = int'(ch) * 2 * IQW + (iq ? 0 : IQW) + (BPW - 1 - int'(b)) * 8;
        return PW'(p);
    endfunction

    always_comb begin
        n_eff = nrx;
        if (nrx == 5'd0) begin
            n_eff = 5'd1;
        end else if (nrx > 5'(NR)) begin
            n_eff = 5'(NR);
        end
    end

    assign hs        = (state_q == DRAIN) && out_if.out_ready;
    assign at_last_q = is_last(ch_q, iq_q, byte_q, n_q);
    assign drop      = (state_q == DRAIN) && rx_strobe && !(hs && at_last_q);

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        n_d         = n_q;
        ch_d        = ch_q;
        iq_d        = iq_q;
        byte_d      = byte_q;
        ovr_flag_d  = ovr_flag_q;
        ovr_count_d = ovr_count_q;

        case (state_q)
            IDLE: begin
                if (rx_strobe) begin
                    snap_d  = rx_data;
                    n_d     = n_eff;
                    ch_d    = '0;
                    iq_d    = 1'b0;
                    byte_d  = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (hs) begin
                    if (at_last_q) begin
                        if (rx_strobe) begin
                            snap_d = rx_data;
                            n_d    = n_eff;
                            ch_d   = '0;
                            iq_d   = 1'b0;
                            byte_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (byte_q == BW'(BPW - 1)) begin
                        byte_d = '0;
                        if (iq_q) begin
                            iq_d = 1'b0;
                            ch_d = ch_q + 5'd1;
                        end else begin
                            iq_d = 1'b1;
                        end
                    end else begin
                        byte_d = byte_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (ovr_clr) begin
            ovr_flag_d  = 1'b0;
            ovr_count_d = 8'd0;
        end else if (drop) begin
            ovr_flag_d = 1'b1;
            if (ovr_count_q != 8'hFF) begin
                ovr_count_d = ovr_count_q + 8'd1;
            end
        end
    end

    // Outputs are computed from next state so they register without any path from ready/strobe
    always_comb begin
        pos_d   = byte_pos(ch_d, iq_d, byte_d);
        valid_d = (state_d == DRAIN);
        data_d  = 8'd0;
        first_d = 1'b0;
        last_d  = 1'b0;
        if (state_d == DRAIN) begin
            data_d  = snap_d[pos_d +: 8];
            first_d = (ch_d == 5'd0) && !iq_d && (byte_d == '0);
            last_d  = is_last(ch_d, iq_d, byte_d, n_d);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            n_q         <= 5'd1;
            ch_q        <= '0;
            iq_q        <= 1'b0;
            byte_q      <= '0;
            ovr_flag_q  <= 1'b0;
            ovr_count_q <= 8'd0;
            data_q      <= 8'd0;
            valid_q     <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            n_q         <= n_d;
            ch_q        <= ch_d;
            iq_q        <= iq_d;
            byte_q      <= byte_d;
            ovr_flag_q  <= ovr_flag_d;
            ovr_count_q <= ovr_count_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            first_q     <= first_d;
            last_q      <= last_d;
        end
    end

    assign out_if.out_data  = data_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_first = first_q;
    assign out_if.out_last  = last_q;
    assign ovr_flag         = ovr_flag_q;
    assign ovr_count        = ovr_count_q;
endmodule
